// File: rtl/fpu_thread_scheduler_if.sv
// Handshake bundle between the two-thread issue stage and the shared FPU scheduler.
interface fpu_thread_scheduler_if;
  logic       req0;
  logic       req1;
  logic       hold0;
  logic       hold1;
  logic       fpu_busy;
  logic       gnt0;
  logic       gnt1;
  logic       dt;
  logic       stall0;
  logic       stall1;
  logic       e1v;
  logic       e2v;
  logic       e3v;
  logic       wv;
  logic       e1t;
  logic       e2t;
  logic       e3t;
  logic       wt;
  logic [2:0] cnt0;
  logic [2:0] cnt1;

  modport master (
    output req0, req1, hold0, hold1, fpu_busy,
    input  gnt0, gnt1, dt, stall0, stall1,
    input  e1v, e2v, e3v, wv, e1t, e2t, e3t, wt, cnt0, cnt1
  );

  modport slave (
    input  req0, req1, hold0, hold1, fpu_busy,
    output gnt0, gnt1, dt, stall0, stall1,
    output e1v, e2v, e3v, wv, e1t, e2t, e3t, wt, cnt0, cnt1
  );
endinterface

// File: rtl/fpu_thread_scheduler.sv
// Round-robin issue arbiter with burst limit for the shared FPU pipeline,
// plus per-stage owner tags so writeback/forwarding reach the right thread.
module fpu_thread_scheduler #(
  parameter int BURST = 1
) (
  input logic                  clk,
  input logic                  rst,
  fpu_thread_scheduler_if.slave bus
);

  localparam logic [2:0] BURST_C = 3'(BURST);

  logic       el0_s;
  logic       el1_s;
  logic       gnt0_s;
  logic       gnt1_s;
  logic       any_gnt_s;
  logic       g_s;
  logic [2:0] cnt0_s;
  logic [2:0] cnt1_s;

  logic       lp_r;
  logic [2:0] bc_r;
  logic       dt_r;
  logic       e1v_r, e2v_r, e3v_r, wv_r;
  logic       e1t_r, e2t_r, e3t_r, wt_r;

  // Eligibility and grant selection; with no grant g_s keeps the last issued thread.
  always_comb begin
    el0_s  = bus.req0 & ~bus.hold0;
    el1_s  = bus.req1 & ~bus.hold1;
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    g_s    = dt_r;
    if (bus.fpu_busy) begin
      g_s = dt_r;
    end else if (el0_s && el1_s) begin
      if (bc_r < BURST_C) begin
        g_s = lp_r;
      end else begin
        g_s = ~lp_r;
      end
      gnt0_s = ~g_s;
      gnt1_s = g_s;
    end else if (el0_s) begin
      g_s    = 1'b0;
      gnt0_s = 1'b1;
    end else if (el1_s) begin
      g_s    = 1'b1;
      gnt1_s = 1'b1;
    end else begin
      g_s = dt_r;
    end
    any_gnt_s = gnt0_s | gnt1_s;
  end

  // Burst bookkeeping: reset leaves thread 1 saturated so thread 0 wins first contest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp_r <= 1'b1;
      bc_r <= BURST_C;
      dt_r <= 1'b0;
    end else if (any_gnt_s) begin
      dt_r <= g_s;
      if (g_s == lp_r) begin
        if (bc_r < BURST_C) begin
          bc_r <= bc_r + 3'd1;
        end else begin
          bc_r <= BURST_C;
        end
      end else begin
        lp_r <= g_s;
        bc_r <= 3'd1;
      end
    end
  end

  // Owner-tag shift register; frozen while div/sqrt iterates, invalid slots carry tag 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e1v_r <= 1'b0;
      e2v_r <= 1'b0;
      e3v_r <= 1'b0;
      wv_r  <= 1'b0;
      e1t_r <= 1'b0;
      e2t_r <= 1'b0;
      e3t_r <= 1'b0;
      wt_r  <= 1'b0;
    end else if (!bus.fpu_busy) begin
      e1v_r <= any_gnt_s;
      e1t_r <= any_gnt_s & g_s;
      e2v_r <= e1v_r;
      e2t_r <= e1v_r & e1t_r;
      e3v_r <= e2v_r;
      e3t_r <= e2v_r & e2t_r;
      wv_r  <= e3v_r;
      wt_r  <= e3v_r & e3t_r;
    end
  end

  // Per-thread occupancy of E1..WB.
  always_comb begin
    cnt0_s = {2'b00, e1v_r & ~e1t_r} + {2'b00, e2v_r & ~e2t_r}
           + {2'b00, e3v_r & ~e3t_r} + {2'b00, wv_r & ~wt_r};
    cnt1_s = {2'b00, e1v_r & e1t_r} + {2'b00, e2v_r & e2t_r}
           + {2'b00, e3v_r & e3t_r} + {2'b00, wv_r & wt_r};
  end

  assign bus.gnt0   = gnt0_s;
  assign bus.gnt1   = gnt1_s;
  assign bus.dt     = g_s;
  assign bus.stall0 = el0_s & ~gnt0_s;
  assign bus.stall1 = el1_s & ~gnt1_s;
  assign bus.e1v    = e1v_r;
  assign bus.e2v    = e2v_r;
  assign bus.e3v    = e3v_r;
  assign bus.wv     = wv_r;
  assign bus.e1t    = e1t_r;
  assign bus.e2t    = e2t_r;
  assign bus.e3t    = e3t_r;
  assign bus.wt     = wt_r;
  assign bus.cnt0   = cnt0_s;
  assign bus.cnt1   = cnt1_s;

endmodule
